// File: rtl/servo_pwm_capture.sv
// -----------------------------------------------------------------------------
// servo_pwm_capture
//
// Receive-side measurement of a servo-style PWM line. The raw pin is brought
// into the clk domain through a two-flop synchroniser plus a history flop.
// Each rising-edge-to-rising-edge period produces one sample that holds:
//   - width:  the high time of that period, in clk cycles
//   - period: the rising-edge-to-rising-edge distance, in clk cycles
// Each sample is range-checked against the legal servo limits. When no rising
// edge arrives for TIMEOUT cycles, signal_lost is raised.
//
// Build option:
//   SERVO_PWM_CAPTURE_INVERT_EN - when defined, the pin is inverted before the
//     synchroniser. Use this for an active-low pulse, as produced by the
//     driver's inverted output stage. "High time" then means pin-low time.
//     When undefined, pwm_in is used as-is (active-high).
//
// Parameters:
//   CNT_W      width of the internal counters and of the width/period outputs
//   MIN_PULSE  minimum legal high time, cycles
//   MAX_PULSE  maximum legal high time, cycles
//   MIN_PERIOD minimum legal period, cycles
//   MAX_PERIOD maximum legal period, cycles
//   TIMEOUT    cycles without a rising edge before signal_lost is raised
//
// Ports:
//   clk           system clock (12 MHz nominal)
//   rst_n         asynchronous active-low reset
//   pwm_in        raw PWM line, asynchronous to clk
//   width         last captured high time, cycles
//   period        last captured period, cycles
//   sample_valid  one-cycle strobe: width/period were just updated
//   in_range      last sample had both width and period within limits
//   signal_lost   no edge activity for TIMEOUT cycles; sticky until next sample
// -----------------------------------------------------------------------------
module servo_pwm_capture #(
  parameter int CNT_W      = 20,
  parameter int MIN_PULSE  = 6000,
  parameter int MAX_PULSE  = 30000,
  parameter int MIN_PERIOD = 180000,
  parameter int MAX_PERIOD = 300000,
  parameter int TIMEOUT    = 360000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             sample_valid,
  output logic             in_range,
  output logic             signal_lost
);

  // FSM encoding
  localparam logic [1:0] ST_WAIT_RISE = 2'd0;
  localparam logic [1:0] ST_HIGH      = 2'd1;
  localparam logic [1:0] ST_LOW       = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Clamp the timeout threshold to the counter range. A counter that is too
  // narrow saturates at CNT_MAX, so the >= compare below still fires.
  localparam longint unsigned CNT_MAX_L  = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned TIMEOUT_L  = (longint'(TIMEOUT) > CNT_MAX_L) ?
                                           CNT_MAX_L : longint'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_L);

  localparam logic [CNT_W-1:0] MIN_PULSE_C  = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_PULSE_C  = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] MIN_PERIOD_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_PERIOD_C = CNT_W'(MAX_PERIOD);

  // Input path: s1/s2 form the synchroniser, s3 is the edge-detect history.
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise, fall;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             sample_valid_q, sample_valid_d;
  logic             in_range_q, in_range_d;
  logic             signal_lost_q, signal_lost_d;

  logic [CNT_W-1:0] hi_inc, per_inc;
  logic             timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic range_ok(input logic [CNT_W-1:0] w,
                                    input logic [CNT_W-1:0] p);
    return (w >= MIN_PULSE_C)  && (w <= MAX_PULSE_C) &&
           (p >= MIN_PERIOD_C) && (p <= MAX_PERIOD_C);
  endfunction

  // Both edges see the same two-cycle synchroniser delay, so the measured
  // high time and period are not affected by it.
  always_comb begin
`ifdef SERVO_PWM_CAPTURE_INVERT_EN
    s1_d = ~pwm_in;
`else
    s1_d = pwm_in;
`endif
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // Timeout is judged on the value per_cnt is about to take. This raises
  // signal_lost exactly TIMEOUT cycles after the rise detection, which lines
  // up with sample_valid's one-cycle latency.
  assign hi_inc  = sat_inc(hi_cnt_q);
  assign per_inc = sat_inc(per_cnt_q);
  assign timeout = (per_inc >= TIMEOUT_C);

  // NOTE: every variable gets a default at the top of the block, so each
  // path through the case assigns it and no latch can be inferred.
  always_comb begin
    state_d        = state_q;
    hi_cnt_d       = hi_cnt_q;
    per_cnt_d      = per_cnt_q;
    width_d        = width_q;
    period_d       = period_q;
    sample_valid_d = 1'b0;
    in_range_d     = in_range_q;
    signal_lost_d  = signal_lost_q;

    case (state_q)
      ST_WAIT_RISE: begin
        // A rise here only starts a measurement; it completes no sample.
        hi_cnt_d  = '0;
        per_cnt_d = '0;
        if (rise) begin
          hi_cnt_d  = CNT_ONE;
          per_cnt_d = CNT_ONE;
          state_d   = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (timeout) begin
          // The line is stuck high.
          state_d       = ST_WAIT_RISE;
          hi_cnt_d      = '0;
          per_cnt_d     = '0;
          signal_lost_d = 1'b1;
          in_range_d    = 1'b0;
        end else if (fall) begin
          // The fall cycle belongs to the low time. hi_cnt freezes here.
          per_cnt_d = per_inc;
          state_d   = ST_LOW;
        end else begin
          hi_cnt_d  = hi_inc;
          per_cnt_d = per_inc;
        end
      end

      ST_LOW: begin
        if (rise) begin
          // Close this period and at once start measuring the next one.
          width_d        = hi_cnt_q;
          period_d       = per_cnt_q;
          sample_valid_d = 1'b1;
          in_range_d     = range_ok(hi_cnt_q, per_cnt_q);
          signal_lost_d  = 1'b0;
          hi_cnt_d       = CNT_ONE;
          per_cnt_d      = CNT_ONE;
          state_d        = ST_HIGH;
        end else if (timeout) begin
          // The line is stuck low.
          state_d       = ST_WAIT_RISE;
          hi_cnt_d      = '0;
          per_cnt_d     = '0;
          signal_lost_d = 1'b1;
          in_range_d    = 1'b0;
        end else begin
          per_cnt_d = per_inc;
        end
      end

      default: begin
        state_d   = ST_WAIT_RISE;
        hi_cnt_d  = '0;
        per_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // updates from values sampled before the edge, so the order of statements
  // in this block does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      state_q        <= ST_WAIT_RISE;
      hi_cnt_q       <= '0;
      per_cnt_q      <= '0;
      width_q        <= '0;
      period_q       <= '0;
      sample_valid_q <= 1'b0;
      in_range_q     <= 1'b0;
      signal_lost_q  <= 1'b1;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      state_q        <= state_d;
      hi_cnt_q       <= hi_cnt_d;
      per_cnt_q      <= per_cnt_d;
      width_q        <= width_d;
      period_q       <= period_d;
      sample_valid_q <= sample_valid_d;
      in_range_q     <= in_range_d;
      signal_lost_q  <= signal_lost_d;
    end
  end

  assign width        = width_q;
  assign period       = period_q;
  assign sample_valid = sample_valid_q;
  assign in_range     = in_range_q;
  assign signal_lost  = signal_lost_q;

endmodule
